// File: rtl/des_core.sv
// des_core: iterative DES encrypt/decrypt engine, one Feistel round per clock (two per clock when DES_TWO_ROUND_EN is defined)
module des_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        des_encipher_en,
  input  logic        des_decipher_en,
  input  logic [63:0] des_data,
  input  logic [63:0] des_key_in,
  output logic        desc_ready,
  output logic [63:0] desc_result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`ifdef DES_TWO_ROUND_EN
  localparam logic [3:0] LAST = 4'd7;
`else
  localparam logic [3:0] LAST = 4'd15;
`endif
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                              16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};
  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
    return o;
  endfunction
  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
    return o;
  endfunction
  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_T[i]];
    return o;
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_T[i]];
    return o;
  endfunction
  function automatic logic [47:0] expand(input logic [31:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = x[32-E_T[i]];
    return o;
  endfunction
  function automatic logic [31:0] pperm(input logic [31:0] x);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[31-i] = x[32-P_T[i]];
    return o;
  endfunction
  // Key-half rotation: left while encrypting, right while decrypting
  function automatic logic [27:0] rot(input logic [27:0] v, input logic right, input int a);
    return a == 0 ? v : right ? (a == 1 ? {v[0], v[27:1]} : {v[1:0], v[27:2]})
                              : (a == 1 ? {v[26:0], v[27]} : {v[25:0], v[27:26]});
  endfunction
  // One Feistel round n (1..16); returns {L, R, C, D} after the round
  function automatic logic [119:0] rnd(input logic [31:0] l, input logic [31:0] r, input logic [27:0] c,
                                       input logic [27:0] d, input logic dec, input int n);
    int a;
    logic [27:0] cn, dn;
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0] b;
    a = dec ? ((n == 1) ? 0 : (n == 2 || n == 9 || n == 16) ? 1 : 2) : ((n <= 2 || n == 9 || n == 16) ? 1 : 2);
    cn = rot(c, dec, a);
    dn = rot(d, dec, a);
    x = expand(r) ^ pc2({cn, dn});
    s = '0;
    for (int j = 0; j < 8; j++) begin
      b = x[47-6*j -: 6];
      s[31-4*j -: 4] = 4'(SBOX[j][{b[5], b[0], b[4:1]}]);
    end
    return {r, l ^ pperm(s), cn, dn};
  endfunction
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic dec_q, dec_d, ready_q, ready_d, start;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] result_q, result_d;
  logic [119:0] t1, nxt;
`ifdef DES_TWO_ROUND_EN
  logic [119:0] t2;
`endif
  // Next-state: accept a start outside BUSY, otherwise advance the rounds and publish on the last one
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dec_d = dec_q;
    ready_d = ready_q;
    l_d = l_q;
    r_d = r_q;
    c_d = c_q;
    d_d = d_q;
    result_d = result_q;
    start = (state_q != BUSY) && (des_encipher_en != des_decipher_en);
`ifdef DES_TWO_ROUND_EN
    t1 = rnd(l_q, r_q, c_q, d_q, dec_q, 2 * int'(cnt_q) + 1);
    t2 = rnd(t1[119:88], t1[87:56], t1[55:28], t1[27:0], dec_q, 2 * int'(cnt_q) + 2);
    nxt = t2;
`else
    t1 = rnd(l_q, r_q, c_q, d_q, dec_q, int'(cnt_q) + 1);
    nxt = t1;
`endif
    if (start) begin
      dec_d = des_decipher_en;
      {l_d, r_d} = ip(des_data);
      {c_d, d_d} = pc1(des_key_in);
      cnt_d = '0;
      ready_d = 1'b0;
      state_d = BUSY;
    end else if (state_q == BUSY) begin
      {l_d, r_d, c_d, d_d} = nxt;
      cnt_d = (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
      if (cnt_q == LAST) begin
        result_d = fp({nxt[87:56], nxt[119:88]});
        ready_d = 1'b1;
        state_d = DONE;
      end
    end
  end
  // State and datapath registers, cleared asynchronously so no partial result survives a reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dec_q <= 1'b0;
      ready_q <= 1'b0;
      l_q <= '0;
      r_q <= '0;
      c_q <= '0;
      d_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dec_q <= dec_d;
      ready_q <= ready_d;
      l_q <= l_d;
      r_q <= r_d;
      c_q <= c_d;
      d_q <= d_d;
      result_q <= result_d;
    end
  end
  assign desc_ready = ready_q;
  assign desc_result = result_q;
endmodule

// File: tb/tb_des_core.sv
// tb_des_core: known-answer table, handshake corner sequences and randomized checks against a textbook DES model
module tb_des_core;
`ifdef DES_TWO_ROUND_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif
  logic clk = 0, rst_n = 0, des_encipher_en = 0, des_decipher_en = 0;
  logic [63:0] des_data = '0, des_key_in = '0;
  logic desc_ready;
  logic [63:0] desc_result;
  int checks = 0, errors = 0;

  des_core dut (.clk(clk), .rst_n(rst_n), .des_encipher_en(des_encipher_en), .des_decipher_en(des_decipher_en),
                .des_data(des_data), .des_key_in(des_key_in), .desc_ready(desc_ready), .desc_result(desc_result));

  always #5 clk = ~clk;

  int IP_T[$] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                  57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int FP_T[$] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                  36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int E_T[$] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                 16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int P_T[$] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int PC1_T[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int PC2_T[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int SH[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int SB[8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Generic DES-numbered permutation: output bit k (1-based, MSB first) takes input bit t[k-1] of an nin-bit word
  function automatic logic [63:0] perm(input logic [63:0] x, input int nin, input int t[$]);
    logic [63:0] o = '0;
    foreach (t[i]) o[t.size()-1-i] = x[nin-t[i]];
    return o;
  endfunction

  // Textbook DES: precompute K1..K16 by cumulative left shifts, decrypt applies them in reverse order
  function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] data, input logic dec);
    logic [63:0] ks[16], lr, er, pv;
    logic [27:0] c, d;
    logic [31:0] l, r, s, t;
    logic [5:0] b;
    lr = perm(key, 64, PC1_T);
    c = lr[55:28];
    d = lr[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < SH[i]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = perm({8'b0, c, d}, 56, PC2_T);
    end
    lr = perm(data, 64, IP_T);
    l = lr[63:32];
    r = lr[31:0];
    for (int i = 0; i < 16; i++) begin
      er = perm({32'b0, r}, 32, E_T) ^ ks[dec ? 15 - i : i];
      s = '0;
      for (int j = 0; j < 8; j++) begin
        b = er[47-6*j -: 6];
        s = (s << 4) | 32'(SB[j][int'({b[5], b[0]}) * 16 + int'(b[4:1])]);
      end
      pv = perm({32'b0, s}, 32, P_T);
      t = r;
      r = l ^ pv[31:0];
      l = t;
    end
    return perm({r, l}, 64, FP_T);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Start an operation with an enable held for len edges; optionally poke an enable and scramble inputs while busy.
  // lat is the number of edges after the start edge at which desc_ready was first seen high.
  task automatic op(input logic dec, input logic [63:0] data, input logic [63:0] key, input int len, input int mid,
                    output int lat);
    @(negedge clk);
    des_data = data;
    des_key_in = key;
    des_encipher_en = !dec;
    des_decipher_en = dec;
    lat = 0;
    @(negedge clk);
    if (len <= 1) begin
      des_encipher_en = 0;
      des_decipher_en = 0;
    end
    while (!desc_ready && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat + 1 >= len) begin
        des_encipher_en = 0;
        des_decipher_en = 0;
      end
      if (mid > 0 && lat == mid) begin
        des_encipher_en = dec;
        des_decipher_en = !dec;
        des_data = ~des_data;
        des_key_in = ~des_key_in;
      end
    end
    des_encipher_en = 0;
    des_decipher_en = 0;
  endtask

  typedef struct {
    logic dec;
    logic [63:0] key, data, exp;
    int len;
  } vec_t;

  vec_t v[6];
  int lat;
  logic [63:0] k, dt, held;
  logic dm;

  initial begin
    v[0] = '{1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 2};
    v[1] = '{1'b1, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1};
    v[2] = '{1'b0, 64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 1};
    v[3] = '{1'b0, 64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000, 1};
    v[4] = '{1'b0, 64'h0101010101010101, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 3};
    v[5] = '{1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, LAT + 1};
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(desc_ready), 0);
    chk("reset_result", desc_result, 0);
    rst_n = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_ready", 64'(desc_ready), 0);
      chk("idle_result", desc_result, 0);
    end
    des_encipher_en = 1;
    des_decipher_en = 1;
    repeat (4) @(negedge clk);
    des_encipher_en = 0;
    des_decipher_en = 0;
    repeat (LAT + 2) @(negedge clk);
    chk("both_idle_ready", 64'(desc_ready), 0);
    for (int i = 0; i < 6; i++) begin
      op(v[i].dec, v[i].data, v[i].key, v[i].len, 0, lat);
      chk($sformatf("kat%0d_latency", i), 64'(lat), 64'(LAT));
      chk($sformatf("kat%0d_result", i), desc_result, v[i].exp);
      chk($sformatf("kat%0d_model", i), desc_result, des_model(v[i].key, v[i].data, v[i].dec));
      repeat (3) @(negedge clk);
      chk($sformatf("kat%0d_hold_ready", i), 64'(desc_ready), 1);
      chk($sformatf("kat%0d_hold_result", i), desc_result, v[i].exp);
    end
    des_encipher_en = 1;
    des_decipher_en = 1;
    des_data = 64'hFFFF0000FFFF0000;
    repeat (4) @(negedge clk);
    des_encipher_en = 0;
    des_decipher_en = 0;
    chk("both_done_ready", 64'(desc_ready), 1);
    chk("both_done_result", desc_result, 64'h85E813540F0AB405);
    op(1'b0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1, 3, lat);
    chk("poke_latency", 64'(lat), 64'(LAT));
    chk("poke_result", desc_result, 64'h85E813540F0AB405);
    @(negedge clk);
    des_data = 64'h0123456789ABCDEF;
    des_key_in = 64'h133457799BBCDFF1;
    des_encipher_en = 1;
    @(negedge clk);
    des_encipher_en = 0;
    repeat (6) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_ready", 64'(desc_ready), 0);
    chk("async_rst_result", desc_result, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (LAT + 2) @(negedge clk);
    chk("post_rst_ready", 64'(desc_ready), 0);
    chk("post_rst_result", desc_result, 0);
    op(1'b0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1, 0, lat);
    chk("post_rst_latency", 64'(lat), 64'(LAT));
    chk("post_rst_kat", desc_result, 64'h85E813540F0AB405);
    for (int i = 0; i < 40; i++) begin
      k = {$urandom, $urandom};
      dt = {$urandom, $urandom};
      dm = 1'($urandom_range(0, 1));
      op(dm, dt, k, $urandom_range(1, 3), $urandom_range(0, 1) ? $urandom_range(2, LAT - 2) : 0, lat);
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(LAT));
      held = des_model(k, dt, dm);
      chk($sformatf("rand%0d_result", i), desc_result, held);
      if (i % 8 == 0) begin
        op(!dm, held, k, 1, 0, lat);
        chk($sformatf("rand%0d_inverse", i), desc_result, dt);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
